// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the ALU-sharing arbiter: FSM states, requester IDs
// and default datapath widths.
package alu_share_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_OPW   = 3;
   localparam int DEF_SHW   = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic REQ_EXEC = 1'b0;
   localparam logic REQ_BR   = 1'b1;

endpackage

// File: rtl/alu_share_arb_if.sv
// Bundle of the two request channels, the ALU drive/return signals and the
// response channel; slave is the arbiter side, master the surrounding logic.
interface alu_share_arb_if
   import alu_share_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int OPW   = DEF_OPW,
   parameter int SHW   = DEF_SHW
);

   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [OPW-1:0]   req0_op;
   logic [SHW-1:0]   req0_sh_amt;
   logic             req0_shift_src;

   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [OPW-1:0]   req1_op;
   logic [SHW-1:0]   req1_sh_amt;
   logic             req1_shift_src;

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [OPW-1:0]   alu_op;
   logic [SHW-1:0]   alu_sh_amt;
   logic             alu_shift_src;
   logic [WIDTH-1:0] alu_result;
   logic             alu_neg;
   logic             alu_zero;
   logic             alu_carry;

   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_neg;
   logic             rsp_zero;
   logic             rsp_carry;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op, req0_sh_amt, req0_shift_src,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_op, req1_sh_amt, req1_shift_src,
      output req1_ready,
      output alu_a, alu_b, alu_op, alu_sh_amt, alu_shift_src,
      input  alu_result, alu_neg, alu_zero, alu_carry,
      output rsp_valid, rsp_id, rsp_result, rsp_neg, rsp_zero, rsp_carry,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_op, req0_sh_amt, req0_shift_src,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_op, req1_sh_amt, req1_shift_src,
      input  req1_ready,
      input  alu_a, alu_b, alu_op, alu_sh_amt, alu_shift_src,
      output alu_result, alu_neg, alu_zero, alu_carry,
      input  rsp_valid, rsp_id, rsp_result, rsp_neg, rsp_zero, rsp_carry,
      output rsp_ready
   );

endinterface

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way round-robin grant. The pointer names the favoured requester on a
// tie and moves to the other requester whenever a grant is taken.
module rr_arb2
   import alu_share_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] valid,
   output logic [1:0] grant
);

   logic ptr;

   always_comb begin
      grant = '0;
      if (en) begin
         if (valid == 2'b11) grant = (ptr == REQ_BR) ? 2'b10 : 2'b01;
         else                grant = valid;
      end
   end

   // grant is only ever raised alongside valid, so any grant is an accept
   always_ff @(posedge clk) begin
      if (rst)         ptr <= REQ_EXEC;
      else if (|grant) ptr <= ~grant[1];
   end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between the execute path and the branch unit: arbitrates,
// holds ALU operands for ALU_LAT cycles, then returns the captured result.
module alu_share_arb
   import alu_share_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int OPW     = DEF_OPW,
   parameter int SHW     = DEF_SHW,
   parameter int ALU_LAT = 1
) (
   input logic             clk,
   input logic             rst,
   alu_share_arb_if.slave  bus
);

   state_t           state;
   logic [3:0]       cnt;
   logic [1:0]       grant;
   logic             sel;

   logic [WIDTH-1:0] alu_a_q;
   logic [WIDTH-1:0] alu_b_q;
   logic [OPW-1:0]   alu_op_q;
   logic [SHW-1:0]   alu_sh_amt_q;
   logic             alu_shift_src_q;

   logic             rsp_valid_q;
   logic             rsp_id_q;
   logic [WIDTH-1:0] rsp_result_q;
   logic             rsp_neg_q;
   logic             rsp_zero_q;
   logic             rsp_carry_q;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .en    (state == ST_IDLE),
      .valid ({bus.req1_valid, bus.req0_valid}),
      .grant (grant)
   );

   assign sel            = grant[1];
   assign bus.req0_ready = grant[0];
   assign bus.req1_ready = grant[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         alu_a_q         <= '0;
         alu_b_q         <= '0;
         alu_op_q        <= '0;
         alu_sh_amt_q    <= '0;
         alu_shift_src_q <= 1'b0;
         rsp_valid_q     <= 1'b0;
         rsp_id_q        <= REQ_EXEC;
         rsp_result_q    <= '0;
         rsp_neg_q       <= 1'b0;
         rsp_zero_q      <= 1'b0;
         rsp_carry_q     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|grant) begin
                  alu_a_q         <= sel ? bus.req1_a         : bus.req0_a;
                  alu_b_q         <= sel ? bus.req1_b         : bus.req0_b;
                  alu_op_q        <= sel ? bus.req1_op        : bus.req0_op;
                  alu_sh_amt_q    <= sel ? bus.req1_sh_amt    : bus.req0_sh_amt;
                  alu_shift_src_q <= sel ? bus.req1_shift_src : bus.req0_shift_src;
                  rsp_id_q        <= sel ? REQ_BR : REQ_EXEC;
                  cnt             <= 4'(ALU_LAT);
                  state           <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  rsp_result_q <= bus.alu_result;
                  rsp_neg_q    <= bus.alu_neg;
                  rsp_zero_q   <= bus.alu_zero;
                  rsp_carry_q  <= bus.alu_carry;
                  rsp_valid_q  <= 1'b1;
                  state        <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.alu_a         = alu_a_q;
   assign bus.alu_b         = alu_b_q;
   assign bus.alu_op        = alu_op_q;
   assign bus.alu_sh_amt    = alu_sh_amt_q;
   assign bus.alu_shift_src = alu_shift_src_q;

   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_neg    = rsp_neg_q;
   assign bus.rsp_zero   = rsp_zero_q;
   assign bus.rsp_carry  = rsp_carry_q;

endmodule
